// File: rtl/serial_addsub_if.sv
// serial_addsub_if: request/result bundle between a controller and serial_addsub_ctrl.
// With SERIAL_ADDSUB_OVF_EN defined, it also carries the signed-overflow flag ovf.
interface serial_addsub_if #(parameter int WIDTH = 8);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
`ifdef SERIAL_ADDSUB_OVF_EN
   logic             ovf;
   modport master (output start, op, a, b, input busy, done, result, cout, ovf);
   modport slave  (input start, op, a, b, output busy, done, result, cout, ovf);
`else
   modport master (output start, op, a, b, input busy, done, result, cout);
   modport slave  (input start, op, a, b, output busy, done, result, cout);
`endif
endinterface

// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: bit-serial add/subtract over one 1-bit cell, LSB first, WIDTH cycles per operation.
// Define SERIAL_ADDSUB_OVF_EN to add the signed-overflow output ovf.
module serial_addsub_ctrl #(parameter int WIDTH = 8) (
   input logic            clk,
   input logic            rst_n,
   serial_addsub_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_a, r_b, r_result;
   logic [CW-1:0]    r_cnt;
   logic             r_op, r_c, r_cout;
   logic             w_ax, w_bi, w_s, w_c, w_last;
`ifdef SERIAL_ADDSUB_OVF_EN
   logic             r_ovf;
`endif
   // Subtraction reuses the carry equation with a inverted, giving the borrow.
   assign w_ax   = r_a[r_cnt] ^ r_op;
   assign w_bi   = r_b[r_cnt];
   assign w_s    = r_a[r_cnt] ^ w_bi ^ r_c;
   assign w_c    = (w_ax & w_bi) | (w_bi & r_c) | (r_c & w_ax);
   assign w_last = r_cnt == CW'(WIDTH - 1);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end
   always_comb begin
      w_next = (r_state == IDLE) ? (bus.start ? RUN : IDLE) :
               (r_state == RUN)  ? (w_last ? DONE : RUN)    : IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= 1'b0;
         r_c      <= 1'b0;
         r_cnt    <= '0;
         r_result <= '0;
         r_cout   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
         r_ovf    <= 1'b0;
`endif
      end else if (r_state == IDLE && bus.start) begin
         r_a   <= bus.a;
         r_b   <= bus.b;
         r_op  <= bus.op;
         r_c   <= 1'b0;
         r_cnt <= '0;
      end else if (r_state == RUN) begin
         r_result <= {w_s, r_result[WIDTH-1:1]};
         r_c      <= w_c;
         r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
         if (w_last) begin
            r_cout <= w_c;
`ifdef SERIAL_ADDSUB_OVF_EN
            // Carry (or borrow) into vs. out of the MSB slice differs exactly on signed overflow.
            r_ovf  <= r_c ^ w_c;
`endif
         end
      end
   end
   always_comb begin
      bus.busy   = r_state != IDLE;
      bus.done   = r_state == DONE;
      bus.result = r_result;
      bus.cout   = r_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
      bus.ovf    = r_ovf;
`endif
   end
endmodule
